// File: rtl/ex7_seq_alu.sv
// Sequential unsigned ALU: single-cycle ADD/SUB/MUL, iterative restoring DIV,
// with valid/ready handshakes on both the request and result sides.
module ex7_seq_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] value1,
    input  logic [WIDTH-1:0] value2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] MODE_ADD = 2'd0;
    localparam logic [1:0] MODE_SUB = 2'd1;
    localparam logic [1:0] MODE_MUL = 2'd2;
    localparam logic [1:0] MODE_DIV = 2'd3;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        DIV_BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  dvd_q, dvd_d;
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [WIDTH-1:0]  result_hi_q, result_hi_d;
    logic              carry_q, carry_d;
    logic              dbz_q, dbz_d;

    logic              accept;
    logic [WIDTH:0]    sum;
    logic [2*WIDTH-1:0] prod;
    logic              trial_ge;
    logic [WIDTH-1:0]  trial_diff;
    logic [WIDTH-1:0]  rem_step;
    logic [WIDTH-1:0]  dvd_step;

    assign in_ready = reset && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    assign sum  = {1'b0, value1} + {1'b0, value2};
    assign prod = {{WIDTH{1'b0}}, value1} * {{WIDTH{1'b0}}, value2};

    // One restoring step: shift next dividend bit into the partial remainder,
    // subtract the divisor if it fits; the dividend register fills with quotient bits.
    assign trial_ge   = ({rem_q, dvd_q[WIDTH-1]} >= {1'b0, dvs_q});
    assign trial_diff = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]} - dvs_q;
    assign rem_step   = trial_ge ? trial_diff : {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
    assign dvd_step   = {dvd_q[WIDTH-2:0], trial_ge};

    // Next-state and output-register logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        carry_d     = carry_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (mode)
                        MODE_ADD: begin
                            out_valid_d = 1'b1;
                            result_d    = sum[WIDTH-1:0];
                            result_hi_d = '0;
                            carry_d     = sum[WIDTH];
                            dbz_d       = 1'b0;
                        end
                        MODE_SUB: begin
                            out_valid_d = 1'b1;
                            result_d    = value1 - value2;
                            result_hi_d = '0;
                            carry_d     = (value1 < value2);
                            dbz_d       = 1'b0;
                        end
                        MODE_MUL: begin
                            out_valid_d = 1'b1;
                            result_d    = prod[WIDTH-1:0];
                            result_hi_d = prod[2*WIDTH-1:WIDTH];
                            carry_d     = 1'b0;
                            dbz_d       = 1'b0;
                        end
                        MODE_DIV: begin
                            if (value2 == '0) begin
                                out_valid_d = 1'b1;
                                result_d    = '1;
                                result_hi_d = value1;
                                carry_d     = 1'b0;
                                dbz_d       = 1'b1;
                            end else begin
                                state_d = DIV_BUSY;
                                cnt_d   = CW'(WIDTH - 1);
                                dvd_d   = value1;
                                dvs_d   = value2;
                                rem_d   = '0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            DIV_BUSY: begin
                dvd_d = dvd_step;
                rem_d = rem_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    result_d    = dvd_step;
                    result_hi_d = rem_step;
                    carry_d     = 1'b0;
                    dbz_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            carry_q     <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            carry_q     <= carry_d;
            dbz_q       <= dbz_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign result_hi   = result_hi_q;
    assign carry       = carry_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_ex7_seq_alu.sv
// Directed self-checking bench for ex7_seq_alu (WIDTH=8); inputs change and
// outputs are sampled on the falling clock edge.
module tb_ex7_seq_alu;

    localparam int unsigned W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   mode;
    logic [W-1:0] value1;
    logic [W-1:0] value2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         carry;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;

    ex7_seq_alu #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mode        (mode),
        .value1      (value1),
        .value2      (value2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .result_hi   (result_hi),
        .carry       (carry),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = v;
        mode     = m;
        value1   = a;
        value2   = b;
    endtask

    task automatic chk_out(input string tag, input logic [W-1:0] r, input logic [W-1:0] rh,
                           input logic c, input logic dz);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".result"}, 32'(result), 32'(r));
        chk({tag, ".result_hi"}, 32'(result_hi), 32'(rh));
        chk({tag, ".carry"}, 32'(carry), 32'(c));
        chk({tag, ".dbz"}, 32'(div_by_zero), 32'(dz));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 2'd0, '0, '0);
        step();
        step();
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.result", 32'(result), 32'd0);
        chk("rst.result_hi", 32'(result_hi), 32'd0);
        chk("rst.carry", 32'(carry), 32'd0);
        chk("rst.dbz", 32'(div_by_zero), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("rel.in_ready", 32'(in_ready), 32'd1);

        // Back-to-back single-cycle operations
        drive(1'b1, 2'd0, 8'd200, 8'd100);
        step();
        chk_out("add200_100", 8'h2C, 8'h00, 1'b1, 1'b0);
        drive(1'b1, 2'd1, 8'd5, 8'd7);
        step();
        chk_out("sub5_7", 8'hFE, 8'h00, 1'b1, 1'b0);
        drive(1'b1, 2'd2, 8'd16, 8'd20);
        step();
        chk_out("mul16_20", 8'h40, 8'h01, 1'b0, 1'b0);
        drive(1'b1, 2'd2, 8'd255, 8'd255);
        step();
        chk_out("mul255_255", 8'h01, 8'hFE, 1'b0, 1'b0);
        drive(1'b0, 2'd0, '0, '0);
        step();
        chk("drain.valid", 32'(out_valid), 32'd0);

        // Iterative divide: busy for WIDTH cycles
        drive(1'b1, 2'd3, 8'd200, 8'd7);
        #1;
        chk("div.in_ready_pre", 32'(in_ready), 32'd1);
        step();
        drive(1'b0, 2'd0, 8'd99, 8'd1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("div.busy%0d.in_ready", k), 32'(in_ready), 32'd0);
            chk($sformatf("div.busy%0d.valid", k), 32'(out_valid), 32'd0);
            step();
        end
        chk_out("div200_7", 8'd28, 8'd4, 1'b0, 1'b0);
        step();
        chk("div.drain", 32'(out_valid), 32'd0);

        // Divide by zero
        drive(1'b1, 2'd3, 8'd37, 8'd0);
        step();
        chk_out("div37_0", 8'hFF, 8'd37, 1'b0, 1'b1);
        drive(1'b0, 2'd0, '0, '0);
        step();

        // Backpressure with a queued request
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 8'd1, 8'd2);
        step();
        drive(1'b1, 2'd0, 8'd4, 8'd4);
        for (int k = 0; k < 5; k++) begin
            chk_out($sformatf("bp%0d", k), 8'd3, 8'd0, 1'b0, 1'b0);
            chk($sformatf("bp%0d.in_ready", k), 32'(in_ready), 32'd0);
            if (k < 4) step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp.in_ready_release", 32'(in_ready), 32'd1);
        step();
        chk_out("bp.add4_4", 8'd8, 8'd0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, '0, '0);
        step();
        chk("bp.drain", 32'(out_valid), 32'd0);

        // Reset in the middle of a divide
        drive(1'b1, 2'd3, 8'd100, 8'd3);
        step();
        drive(1'b0, 2'd0, '0, '0);
        step();
        step();
        reset = 1'b0;
        step();
        chk("rdiv.valid", 32'(out_valid), 32'd0);
        chk("rdiv.result", 32'(result), 32'd0);
        chk("rdiv.result_hi", 32'(result_hi), 32'd0);
        chk("rdiv.in_ready_low", 32'(in_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("rdiv.in_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 2'd0, 8'd1, 8'd1);
        step();
        chk_out("rdiv.add1_1", 8'd2, 8'd0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, '0, '0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("rdiv.quiet%0d", k), 32'(out_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
